// File: rtl/mem_ws_pkg.sv
// Shared definitions for the memory wait-state sequencer.
// Optional feature macro: MEM_WS_WRITE_PROTECT_EN (blocks write strobes to ROM).
package mem_ws_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic REG_RAM = 1'b0;
  localparam logic REG_ROM = 1'b1;

  localparam int DEF_ROM_WS  = 2;
  localparam int DEF_RAM_WS  = 0;
  localparam int DEF_WS_BITS = 4;

`ifdef MEM_WS_WRITE_PROTECT_EN
  localparam logic WP_EN = 1'b1;
`else
  localparam logic WP_EN = 1'b0;
`endif

  // Strobe/berr values on entry to ACCESS: {nmemr, nmemw, berr}.
  function automatic logic [2:0] access_entry(input logic wr, input logic rom);
    if (wr && rom && WP_EN) return 3'b111;
    else if (wr)            return 3'b100;
    else                    return 3'b010;
  endfunction

endpackage

// File: rtl/mem_ws_counter.sv
// Loadable down-counter used to time the wait states.
module mem_ws_counter
  import mem_ws_pkg::*;
#(
  parameter int WS_BITS = DEF_WS_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_dec,
  input  logic [WS_BITS-1:0] i_load_val,
  output logic               o_at_one
);

  logic [WS_BITS-1:0] r_cnt;

  // Load takes priority over decrement.
  always_ff @(posedge clk) begin
    if (reset)       r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_at_one = (r_cnt == {{(WS_BITS-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mem_ws_seq.sv
// Memory wait-state sequencer: latches the bank, decodes ROM/RAM, inserts
// per-region wait states, then drives the read/write strobes.
// Optional feature macro: MEM_WS_WRITE_PROTECT_EN (see mem_ws_pkg).
module mem_ws_seq
  import mem_ws_pkg::*;
#(
  parameter int ROM_WS  = DEF_ROM_WS,
  parameter int RAM_WS  = DEF_RAM_WS,
  parameter int WS_BITS = DEF_WS_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] aext,
  input  logic [15:0] ab,
  input  logic       nmem,
  input  logic       nr,
  input  logic       nw,
  output logic [7:0] bank_q,
  output logic       ncs_rom,
  output logic       ncs_ram,
  output logic       nmemr,
  output logic       nmemw,
  output logic       nwaiting,
  output logic       berr
);

  localparam logic [WS_BITS-1:0] ROM_WS_V = WS_BITS'(ROM_WS);
  localparam logic [WS_BITS-1:0] RAM_WS_V = WS_BITS'(RAM_WS);

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_bank, w_bank_nxt;
  logic               r_region, w_region_nxt;
  logic               r_dir_wr, w_dir_wr_nxt;
  logic               r_ncs_rom, w_ncs_rom_nxt;
  logic               r_ncs_ram, w_ncs_ram_nxt;
  logic               r_nmemr, w_nmemr_nxt;
  logic               r_nmemw, w_nmemw_nxt;
  logic               r_nwaiting, w_nwaiting_nxt;
  logic               r_berr, w_berr_nxt;
  logic               w_load, w_dec, w_at_one;
  logic [WS_BITS-1:0] w_ws_sel;
  logic [2:0]         w_entry;
  logic               w_unused_ab;

  // The address bus carries no information this block needs.
  assign w_unused_ab = ^ab;

  mem_ws_counter #(.WS_BITS(WS_BITS)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_dec      (w_dec),
    .i_load_val (w_ws_sel),
    .o_at_one   (w_at_one)
  );

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt    = r_state;
    w_bank_nxt     = r_bank;
    w_region_nxt   = r_region;
    w_dir_wr_nxt   = r_dir_wr;
    w_ncs_rom_nxt  = r_ncs_rom;
    w_ncs_ram_nxt  = r_ncs_ram;
    w_nmemr_nxt    = r_nmemr;
    w_nmemw_nxt    = r_nmemw;
    w_nwaiting_nxt = r_nwaiting;
    w_berr_nxt     = 1'b0;
    w_load         = 1'b0;
    w_dec          = 1'b0;
    w_ws_sel       = aext[7] ? ROM_WS_V : RAM_WS_V;
    w_entry        = 3'b110;
    case (r_state)
      ST_IDLE: begin
        w_ncs_rom_nxt  = 1'b1;
        w_ncs_ram_nxt  = 1'b1;
        w_nmemr_nxt    = 1'b1;
        w_nmemw_nxt    = 1'b1;
        w_nwaiting_nxt = 1'b1;
        if (!nmem && (nr ^ nw)) begin
          w_bank_nxt    = aext;
          w_region_nxt  = aext[7] ? REG_ROM : REG_RAM;
          w_dir_wr_nxt  = !nw;
          w_ncs_rom_nxt = !aext[7];
          w_ncs_ram_nxt = aext[7];
          if (w_ws_sel != '0) begin
            w_load         = 1'b1;
            w_nwaiting_nxt = 1'b0;
            w_state_nxt    = ST_WAIT;
          end else begin
            w_entry     = access_entry(!nw, aext[7]);
            w_nmemr_nxt = w_entry[2];
            w_nmemw_nxt = w_entry[1];
            w_berr_nxt  = w_entry[0];
            w_state_nxt = ST_ACCESS;
          end
        end else if (!nmem && !nr && !nw) begin
          w_berr_nxt  = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_WAIT: begin
        if (nmem) begin
          w_ncs_rom_nxt  = 1'b1;
          w_ncs_ram_nxt  = 1'b1;
          w_nwaiting_nxt = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else if (w_at_one) begin
          w_entry        = access_entry(r_dir_wr, r_region == REG_ROM);
          w_nmemr_nxt    = w_entry[2];
          w_nmemw_nxt    = w_entry[1];
          w_berr_nxt     = w_entry[0];
          w_nwaiting_nxt = 1'b1;
          w_state_nxt    = ST_ACCESS;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (nmem) begin
          w_ncs_rom_nxt = 1'b1;
          w_ncs_ram_nxt = 1'b1;
          w_nmemr_nxt   = 1'b1;
          w_nmemw_nxt   = 1'b1;
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (nmem) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset overrides any cycle in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bank     <= 8'h00;
      r_region   <= REG_RAM;
      r_dir_wr   <= 1'b0;
      r_ncs_rom  <= 1'b1;
      r_ncs_ram  <= 1'b1;
      r_nmemr    <= 1'b1;
      r_nmemw    <= 1'b1;
      r_nwaiting <= 1'b1;
      r_berr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bank     <= w_bank_nxt;
      r_region   <= w_region_nxt;
      r_dir_wr   <= w_dir_wr_nxt;
      r_ncs_rom  <= w_ncs_rom_nxt;
      r_ncs_ram  <= w_ncs_ram_nxt;
      r_nmemr    <= w_nmemr_nxt;
      r_nmemw    <= w_nmemw_nxt;
      r_nwaiting <= w_nwaiting_nxt;
      r_berr     <= w_berr_nxt;
    end
  end

  assign bank_q   = r_bank;
  assign ncs_rom  = r_ncs_rom;
  assign ncs_ram  = r_ncs_ram;
  assign nmemr    = r_nmemr;
  assign nmemw    = r_nmemw;
  assign nwaiting = r_nwaiting;
  assign berr     = r_berr;

endmodule
